// File: rtl/bellek_hakemi_pkg.sv
// Shared constants, FSM encoding and request payload for the main-memory arbiter.
package bellek_hakemi_pkg;

    localparam int unsigned ADRES_BIT    = 32;
    localparam int unsigned VERI_BIT     = 32;
    localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
    localparam int unsigned BELLEK_SATIR = 1024;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        ERISIM = 2'd1,
        YANIT  = 2'd2
    } durum_t;

    // One requester's access as seen at grant time
    typedef struct packed {
        logic [ADRES_BIT-1:0] adres;
        logic                 yaz;
        logic [VERI_BIT-1:0]  veri;
    } istek_t;

endpackage

// File: rtl/bellek_hakemi_hakem_rr.sv
// Two-way round-robin chooser: a lone candidate wins, a tie goes to the port not served last.
module bellek_hakemi_hakem_rr (
    input  logic [1:0] istek,
    input  logic [1:0] maske,
    input  logic       son_hizmet,
    output logic       gecerli,
    output logic       secim
);

    logic [1:0] aday;

    // Masked candidates and the round-robin pick among them
    always_comb begin
        aday    = istek & ~maske;
        gecerli = |aday;
        secim   = aday[1] & (~aday[0] | ~son_hizmet);
    end

endmodule

// File: rtl/bellek_hakemi.sv
// Shares the single-port main memory between the processor (port 0) and the loader (port 1).
module bellek_hakemi
    import bellek_hakemi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 istek0,
    input  logic [ADRES_BIT-1:0] adres0,
    input  logic                 yaz0,
    input  logic [VERI_BIT-1:0]  yaz_veri0,
    output logic                 hazir0,
    output logic                 hata0,
    output logic [VERI_BIT-1:0]  oku_veri0,
    input  logic                 istek1,
    input  logic [ADRES_BIT-1:0] adres1,
    input  logic                 yaz1,
    input  logic [VERI_BIT-1:0]  yaz_veri1,
    output logic                 hazir1,
    output logic                 hata1,
    output logic [VERI_BIT-1:0]  oku_veri1,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

    durum_t               durum_q, durum_d;
    logic                 secim_q, son_hizmet_q, hata_q, yaz_q;
    logic [1:0]           maske_c;
    logic                 gecerli_c, secim_c, al_c, hata_c;
    istek_t               aday_c;
    logic [ADRES_BIT-1:0] ofset_c;
    logic [VERI_BIT-1:0]  oku_c;

    bellek_hakemi_hakem_rr u_hakem (
        .istek      ({istek1, istek0}),
        .maske      (maske_c),
        .son_hizmet (son_hizmet_q),
        .gecerli    (gecerli_c),
        .secim      (secim_c)
    );

    // The port being answered still holds istek, so it cannot win in its own completion cycle
    assign maske_c = (durum_q == YANIT) ? (secim_q ? 2'b10 : 2'b01) : 2'b00;

    // Winner's payload, range/alignment check and the value to capture for the requester
    always_comb begin
        aday_c  = secim_c ? istek_t'({adres1, yaz1, yaz_veri1})
                          : istek_t'({adres0, yaz0, yaz_veri0});
        ofset_c = aday_c.adres - BELLEK_ADRES;
        hata_c  = (aday_c.adres[1:0] != 2'b00) ||
                  (ofset_c >= ADRES_BIT'(4 * BELLEK_SATIR));
        oku_c   = (yaz_q || hata_q) ? '0 : bellek_oku_veri;
    end

    // Next-state and grant decision
    always_comb begin
        durum_d = durum_q;
        al_c    = 1'b0;
        case (durum_q)
            BOS: begin
                if (gecerli_c) begin
                    al_c    = 1'b1;
                    durum_d = ERISIM;
                end
            end
            ERISIM: durum_d = YANIT;
            YANIT: begin
                if (gecerli_c) begin
                    al_c    = 1'b1;
                    durum_d = ERISIM;
                end else begin
                    durum_d = BOS;
                end
            end
            default: durum_d = BOS;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) durum_q <= BOS;
        else        durum_q <= durum_d;
    end

    // Latch the granted access; memory bus holds its last value between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secim_q         <= 1'b0;
            son_hizmet_q    <= 1'b1;
            hata_q          <= 1'b0;
            yaz_q           <= 1'b0;
            bellek_adres    <= '0;
            bellek_yaz_veri <= '0;
            bellek_yaz      <= 1'b0;
        end else begin
            bellek_yaz <= al_c & aday_c.yaz & ~hata_c;
            if (al_c) begin
                secim_q         <= secim_c;
                son_hizmet_q    <= secim_c;
                hata_q          <= hata_c;
                yaz_q           <= aday_c.yaz;
                bellek_adres    <= aday_c.adres;
                bellek_yaz_veri <= aday_c.veri;
            end
        end
    end

    // Completion strobe, error flag and read data routed to the served port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazir0    <= 1'b0;
            hazir1    <= 1'b0;
            hata0     <= 1'b0;
            hata1     <= 1'b0;
            oku_veri0 <= '0;
            oku_veri1 <= '0;
        end else begin
            hazir0 <= (durum_q == ERISIM) & ~secim_q;
            hazir1 <= (durum_q == ERISIM) &  secim_q;
            hata0  <= (durum_q == ERISIM) & ~secim_q & hata_q;
            hata1  <= (durum_q == ERISIM) &  secim_q & hata_q;
            if (durum_q == ERISIM) begin
                if (secim_q) oku_veri1 <= oku_c;
                else         oku_veri0 <= oku_c;
            end
        end
    end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: memory model, transaction-level reference and directed scenarios.
module tb_bellek_hakemi;
    import bellek_hakemi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        istek0 = 1'b0, istek1 = 1'b0;
    logic [31:0] adres0 = '0, adres1 = '0;
    logic        yaz0 = 1'b0, yaz1 = 1'b0;
    logic [31:0] yaz_veri0 = '0, yaz_veri1 = '0;
    logic        hazir0, hazir1, hata0, hata1;
    logic [31:0] oku_veri0, oku_veri1;
    logic [31:0] bellek_adres, bellek_yaz_veri, bellek_oku_veri;
    logic        bellek_yaz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bellek_hakemi dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .istek0          (istek0),
        .adres0          (adres0),
        .yaz0            (yaz0),
        .yaz_veri0       (yaz_veri0),
        .hazir0          (hazir0),
        .hata0           (hata0),
        .oku_veri0       (oku_veri0),
        .istek1          (istek1),
        .adres1          (adres1),
        .yaz1            (yaz1),
        .yaz_veri1       (yaz_veri1),
        .hazir1          (hazir1),
        .hata1           (hata1),
        .oku_veri1       (oku_veri1),
        .bellek_adres    (bellek_adres),
        .bellek_yaz_veri (bellek_yaz_veri),
        .bellek_yaz      (bellek_yaz),
        .bellek_oku_veri (bellek_oku_veri)
    );

    // Main memory attached to the arbiter, plus a reference copy owned by the model
    logic [31:0] phys_mem [1024];
    logic [31:0] ref_mem  [1024];
    logic [31:0] bofs;

    always_comb begin
        bofs            = bellek_adres - 32'h8000_0000;
        bellek_oku_veri = (bofs < 32'd4096) ? phys_mem[bofs[11:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (bellek_yaz && bofs < 32'd4096) phys_mem[bofs[11:2]] <= bellek_yaz_veri;
    end

    function automatic bit adres_hatali(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'h8000_0000;
        return (a[1:0] != 2'b00) || (o >= 32'd4096);
    endfunction

    function automatic int satir(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'h8000_0000;
        return int'(o[11:2]);
    endfunction

    task automatic chk(input string ad, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", ad, got, exp, $time);
        end
    endtask

    // Reference: one access in flight; a grant can be made in any cycle that is not the
    // memory-access cycle of the previous grant; completion two cycles after the grant.
    typedef struct {
        int          g;
        int          p;
        logic [31:0] a;
        logic        y;
        logic [31:0] v;
        logic        h;
        logic [31:0] d;
    } islem_t;

    islem_t     fl;
    bit         fl_v = 1'b0;
    bit         m_son = 1'b1;
    bit         e_er, e_ya;
    logic [1:0] aday;
    int         bos_port, kazanan;
    int         cyc = 0;
    int         yaz_darbe = 0;
    int         hz_port[$];
    int         hz_cyc[$];

    // Compare DUT against the reference every cycle, then advance the reference
    always @(negedge clk) begin
        cyc++;
        if (bellek_yaz) yaz_darbe++;
        chk("hazir_cakisma", 32'(hazir0 & hazir1), 32'd0);
        if (!rst_n) begin
            chk("reset_hazir0", 32'(hazir0), 32'd0);
            chk("reset_hazir1", 32'(hazir1), 32'd0);
            chk("reset_bellek_yaz", 32'(bellek_yaz), 32'd0);
            chk("reset_hata", 32'({hata1, hata0}), 32'd0);
            fl_v  = 1'b0;
            m_son = 1'b1;
        end else begin
            e_er = fl_v && (cyc == fl.g + 1);
            e_ya = fl_v && (cyc == fl.g + 2);
            chk("bellek_yaz", 32'(bellek_yaz), 32'(e_er && fl.y && !fl.h));
            if (e_er) begin
                chk("bellek_adres", bellek_adres, fl.a);
                if (fl.y && !fl.h) chk("bellek_yaz_veri", bellek_yaz_veri, fl.v);
            end
            chk("hazir0", 32'(hazir0), 32'(e_ya && fl.p == 0));
            chk("hazir1", 32'(hazir1), 32'(e_ya && fl.p == 1));
            if (hazir0 || hazir1) begin
                hz_port.push_back(hazir1 ? 1 : 0);
                hz_cyc.push_back(cyc);
            end
            bos_port = -1;
            if (e_ya) begin
                if (fl.p == 0) begin
                    chk("hata0", 32'(hata0), 32'(fl.h));
                    chk("oku_veri0", oku_veri0, fl.d);
                end else begin
                    chk("hata1", 32'(hata1), 32'(fl.h));
                    chk("oku_veri1", oku_veri1, fl.d);
                end
                if (fl.y && !fl.h) ref_mem[satir(fl.a)] = fl.v;
                bos_port = fl.p;
                fl_v     = 1'b0;
            end
            if (!e_er) begin
                aday = {istek1, istek0};
                if (bos_port == 0) aday[0] = 1'b0;
                if (bos_port == 1) aday[1] = 1'b0;
                if (aday != 2'b00) begin
                    if (aday == 2'b11) kazanan = m_son ? 0 : 1;
                    else               kazanan = aday[1] ? 1 : 0;
                    m_son = (kazanan == 1);
                    fl.g  = cyc;
                    fl.p  = kazanan;
                    fl.a  = (kazanan == 1) ? adres1 : adres0;
                    fl.y  = (kazanan == 1) ? yaz1 : yaz0;
                    fl.v  = (kazanan == 1) ? yaz_veri1 : yaz_veri0;
                    fl.h  = adres_hatali(fl.a);
                    if (fl.y || fl.h) fl.d = 32'h0;
                    else              fl.d = ref_mem[satir(fl.a)];
                    fl_v = 1'b1;
                end
            end
        end
    end

    // One requester transaction; lat is the cycle distance from istek sampling to hazir
    task automatic islem(input int p, input logic [31:0] a, input logic y, input logic [31:0] v,
                         input bit birak, output logic [31:0] rd, output logic h, output int lat);
        int n = 0;
        bit gordu = 1'b0;
        rd = '0;
        h  = 1'b0;
        if (p == 0) begin istek0 = 1'b1; adres0 = a; yaz0 = y; yaz_veri0 = v; end
        else        begin istek1 = 1'b1; adres1 = a; yaz1 = y; yaz_veri1 = v; end
        while (!gordu && n < 20) begin
            @(negedge clk);
            n++;
            if ((p == 0 && hazir0) || (p == 1 && hazir1)) begin
                gordu = 1'b1;
                rd    = (p == 0) ? oku_veri0 : oku_veri1;
                h     = (p == 0) ? hata0 : hata1;
            end
        end
        lat = n - 1;
        if (!gordu) begin
            checks++;
            errors++;
            $display("FAIL islem_timeout port%0d: no hazir within 20 cycles", p);
        end
        @(posedge clk);
        #1;
        if (birak) begin
            if (p == 0) istek0 = 1'b0;
            else        istek1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        istek0 = 1'b0;
        istek1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] r0, r1;
    logic        h0, h1;
    int          l0, l1, darbe0, farklar;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = 32'h1000_0000 + 32'(i);
            ref_mem[i]  = 32'h1000_0000 + 32'(i);
        end
        phys_mem[1] = 32'h4040_8b33; ref_mem[1] = 32'h4040_8b33;
        phys_mem[8] = 32'h1111_2222; ref_mem[8] = 32'h1111_2222;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_bellek_adres", bellek_adres, 32'h0);
        chk("reset_oku_veri0", oku_veri0, 32'h0);
        rst_n = 1'b1;

        // 1: single read, latency and no write pulse
        darbe0 = yaz_darbe;
        islem(0, 32'h8000_0004, 1'b0, 32'h0, 1'b1, r0, h0, l0);
        chk("t1_oku_veri", r0, 32'h4040_8b33);
        chk("t1_hata", 32'(h0), 32'd0);
        chk("t1_gecikme", 32'(l0), 32'd2);
        chk("t1_yaz_darbe", 32'(yaz_darbe - darbe0), 32'd0);

        // 2: simultaneous requests after reset, port 0 first
        do_reset();
        hz_port.delete(); hz_cyc.delete();
        fork
            islem(0, 32'h8000_0008, 1'b0, 32'h0, 1'b1, r0, h0, l0);
            islem(1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 1'b1, r1, h1, l1);
        join
        chk("t2_ilk_port", 32'(hz_port[0]), 32'd0);
        chk("t2_ikinci_port", 32'(hz_port[1]), 32'd1);
        chk("t2_oku_veri0", r0, 32'h1000_0002);
        islem(0, 32'h8000_0010, 1'b0, 32'h0, 1'b1, r0, h0, l0);
        chk("t2_geri_oku", r0, 32'hDEAD_BEEF);

        // 3: continuous load on both ports
        do_reset();
        hz_port.delete(); hz_cyc.delete();
        fork
            begin : yuk0
                logic [31:0] r;
                logic hh;
                int l;
                for (int i = 0; i < 10; i++)
                    islem(0, 32'h8000_0100 + 32'(4 * i), 1'(i % 2), 32'hA000_0000 + 32'(i),
                          (i == 9), r, hh, l);
            end
            begin : yuk1
                logic [31:0] r;
                logic hh;
                int l;
                for (int i = 0; i < 10; i++)
                    islem(1, 32'h8000_0200 + 32'(4 * i), 1'((i + 1) % 2), 32'hB000_0000 + 32'(i),
                          (i == 9), r, hh, l);
            end
        join
        chk("t3_adet", 32'(hz_port.size()), 32'd20);
        for (int i = 0; i < hz_port.size(); i++) begin
            chk("t3_sira", 32'(hz_port[i]), 32'(i % 2));
            if (i > 0) chk("t3_aralik", 32'(hz_cyc[i] - hz_cyc[i-1]), 32'd2);
        end

        // 4: out-of-range write and misaligned read
        darbe0 = yaz_darbe;
        fork
            islem(0, 32'h7FFF_FFFC, 1'b1, 32'h1234_5678, 1'b1, r0, h0, l0);
            islem(1, 32'h8000_0002, 1'b0, 32'h0, 1'b1, r1, h1, l1);
        join
        chk("t4_hata0", 32'(h0), 32'd1);
        chk("t4_hata1", 32'(h1), 32'd1);
        chk("t4_oku_veri1", r1, 32'h0);
        chk("t4_yaz_darbe", 32'(yaz_darbe - darbe0), 32'd0);

        // 5: reset during the memory-access cycle of a write
        do_reset();
        hz_port.delete(); hz_cyc.delete();
        @(posedge clk);
        #1;
        istek0 = 1'b1; adres0 = 32'h8000_0020; yaz0 = 1'b1; yaz_veri0 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("t5_yaz_oncesi", 32'(bellek_yaz), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_yaz_async", 32'(bellek_yaz), 32'd0);
        istek0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_hazir_yok", 32'(hz_port.size()), 32'd0);
        chk("t5_bellek", phys_mem[8], 32'h1111_2222);
        fork
            islem(0, 32'h8000_0020, 1'b0, 32'h0, 1'b1, r0, h0, l0);
            islem(1, 32'h8000_0024, 1'b0, 32'h0, 1'b1, r1, h1, l1);
        join
        chk("t5_ilk_port", 32'(hz_port[0]), 32'd0);
        chk("t5_oku_veri0", r0, 32'h1111_2222);

        // 6: port 1 keeps istek high through its own hazir
        hz_port.delete(); hz_cyc.delete();
        islem(1, 32'h8000_0030, 1'b0, 32'h0, 1'b0, r1, h1, l1);
        islem(1, 32'h8000_0034, 1'b0, 32'h0, 1'b1, r1, h1, l1);
        chk("t6_adet", 32'(hz_port.size()), 32'd2);
        chk("t6_aralik", 32'(hz_cyc[1] - hz_cyc[0]), 32'd3);
        chk("t6_oku_veri1", r1, 32'h1000_000D);

        repeat (3) @(posedge clk);
        farklar = 0;
        for (int i = 0; i < 1024; i++) if (phys_mem[i] !== ref_mem[i]) farklar++;
        chk("bellek_icerik", 32'(farklar), 32'd0);
        chk("bellek_w1", phys_mem[1], 32'h4040_8b33);
        chk("bellek_w4", phys_mem[4], 32'hDEAD_BEEF);
        chk("bellek_w8", phys_mem[8], 32'h1111_2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
